prog_jmp_counter: RTL

- Parametrised successor to the fixed 4-bit jump counter.
- Up/down counter of configurable width and modulus, with a runtime-programmable table of NUM_JUMPS jump entries (from -> to) applied when counting up.
- Adds enable, synchronous load, direction control, and single-cycle event pulses (jump, wrap).
- Sits as a sequencer/address generator driven by the system clock.

---
 rtl/prog_jmp_counter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/prog_jmp_counter.sv
// Up/down counter with a programmable jump table and jump/wrap pulses.
// Optional JMP_CNT_STATS_EN adds a saturating jump counter with clear.
module prog_jmp_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 15,
  parameter int NUM_JUMPS = 2,
  parameter int RST_FROM  = 5,
  parameter int RST_TO    = 9,
  localparam int IDXW     = (NUM_JUMPS > 1) ? $clog2(NUM_JUMPS) : 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_from,
  input  logic [WIDTH-1:0] wr_to,
  input  logic             wr_valid,
`ifdef JMP_CNT_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      jump_cnt,
`endif
  output logic [WIDTH-1:0] count,
  output logic             jumped,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             jumped_q, jumped_d;
  logic             wrapped_q, wrapped_d;

  logic [NUM_JUMPS-1:0]            vld_q, vld_d;
  logic [NUM_JUMPS-1:0][WIDTH-1:0] from_q, from_d;
  logic [NUM_JUMPS-1:0][WIDTH-1:0] to_q, to_d;

  logic             hit;
  logic [WIDTH-1:0] tgt;
  logic             wr_ok;

  // Lowest matching valid entry wins; uses the table as it was before this edge.
  always_comb begin
    hit = 1'b0;
    tgt = '0;
    for (int i = 0; i < NUM_JUMPS; i++) begin
      if (!hit && vld_q[i] && from_q[i] == count_q) begin
        hit = 1'b1;
        tgt = to_q[i];
      end
    end
    if (tgt > MAXV) tgt = MAXV;
  end

  always_comb begin
    count_d   = count_q;
    jumped_d  = 1'b0;
    wrapped_d = 1'b0;
    if (load) begin
      count_d = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (dir) begin
        if (hit) begin
          count_d  = tgt;
          jumped_d = 1'b1;
        end else if (count_q == MAXV) begin
          count_d   = '0;
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d   = MAXV;
          wrapped_d = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  assign wr_ok = wr_en && (32'(wr_idx) < 32'(NUM_JUMPS));

  always_comb begin
    vld_d  = vld_q;
    from_d = from_q;
    to_d   = to_q;
    if (wr_ok) begin
      vld_d[wr_idx]  = wr_valid;
      from_d[wr_idx] = wr_from;
      to_d[wr_idx]   = wr_to;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_q   <= '0;
      jumped_q  <= 1'b0;
      wrapped_q <= 1'b0;
      vld_q     <= NUM_JUMPS'(1);
      from_q    <= '0;
      to_q      <= '0;
      from_q[0] <= WIDTH'(RST_FROM);
      to_q[0]   <= WIDTH'(RST_TO);
    end else begin
      count_q   <= count_d;
      jumped_q  <= jumped_d;
      wrapped_q <= wrapped_d;
      vld_q     <= vld_d;
      from_q    <= from_d;
      to_q      <= to_d;
    end
  end

  assign count   = count_q;
  assign jumped  = jumped_q;
  assign wrapped = wrapped_q;

`ifdef JMP_CNT_STATS_EN
  logic [15:0] jcnt_q, jcnt_d;

  always_comb begin
    jcnt_d = jcnt_q;
    if (load || stats_clr) begin
      jcnt_d = '0;
    end else if (jumped_d && jcnt_q != 16'hFFFF) begin
      jcnt_d = jcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) jcnt_q <= '0;
    else         jcnt_q <= jcnt_d;
  end

  assign jump_cnt = jcnt_q;
`endif

endmodule
